mac_feeder: RTL and testbench

Operand sequencer for `multiply_accumulate` in the image-processing pipeline. On `start` it latches a window of DATA_LEN pixel samples and DATA_LEN coefficients, pulses the MAC's clear, then streams one operand pair per accepted cycle. After the MAC pipeline drains it captures the accumulated result and overflow flag and reports them with a one-cycle `done`. It is the driving end of the MAC operand/result interface; downstream convolution stages use it to compute one kernel tap sum per window.

---
 rtl/mac_feeder.sv | 143 ++++++++++++++
 tb/tb_mac_feeder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mac_feeder.sv
// Operand sequencer for multiply_accumulate: window in, one cycle of MAC clear, pairs streamed under mac_ready, result out after LAT drain cycles.
// Optional MAC_FEEDER_SATURATE_EN clamps an overflowed captured result to all ones.
module mac_feeder #(
  parameter int DATA_W   = 4,
  parameter int RESULT_W = 16,
  parameter int DATA_LEN = 8,
  parameter int LAT      = 1
) (
  input  logic                         clk,
  input  logic                         aresetn,
  input  logic                         start,
  input  logic [DATA_LEN*DATA_W-1:0]   data_in,
  input  logic [DATA_LEN*DATA_W-1:0]   multi_in,
  output logic                         busy,
  output logic                         mac_reset,
  output logic                         mac_valid,
  input  logic                         mac_ready,
  output logic [DATA_W-1:0]            mac_a,
  output logic [DATA_W-1:0]            mac_b,
  input  logic [RESULT_W-1:0]          mac_result,
  input  logic                         mac_overflow,
  output logic [RESULT_W-1:0]          result,
  output logic                         overflow,
  output logic                         done
);

  localparam int IW = (DATA_LEN > 1) ? $clog2(DATA_LEN) : 1;
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [2:0] {IDLE, CLEAR, ISSUE, DRAIN, DONE} state_t;

  state_t                           state_q, state_d;
  logic [IW-1:0]                    idx_q, idx_d;
  logic [CW-1:0]                    cnt_q, cnt_d;
  logic [DATA_LEN-1:0][DATA_W-1:0]  data_q, data_d;
  logic [DATA_LEN-1:0][DATA_W-1:0]  multi_q, multi_d;
  logic [RESULT_W-1:0]              result_q, result_d;
  logic                             overflow_q, overflow_d;
  logic                             done_q, done_d;
  logic                             busy_q, busy_d;
  logic                             mac_reset_q, mac_reset_d;
  logic                             mac_valid_q, mac_valid_d;
  logic [DATA_W-1:0]                mac_a_q, mac_a_d;
  logic [DATA_W-1:0]                mac_b_q, mac_b_d;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    multi_d     = multi_q;
    result_d    = result_q;
    overflow_d  = overflow_q;
    mac_reset_d = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          data_d      = data_in;
          multi_d     = multi_in;
          idx_d       = '0;
          cnt_d       = '0;
          mac_reset_d = 1'b1;
          state_d     = CLEAR;
        end
      end
      CLEAR: state_d = ISSUE;
      ISSUE: begin
        if (mac_valid_q && mac_ready) begin
          if (idx_q == IW'(DATA_LEN - 1)) begin
            cnt_d   = '0;
            state_d = DRAIN;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (cnt_q == CW'(LAT - 1)) begin
`ifdef MAC_FEEDER_SATURATE_EN
          result_d = mac_overflow ? {RESULT_W{1'b1}} : mac_result;
`else
          result_d = mac_result;
`endif
          overflow_d = mac_overflow;
          done_d     = 1'b1;
          state_d    = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Outputs are registered from the next state so they line up with it.
    busy_d      = (state_d != IDLE);
    mac_valid_d = (state_d == ISSUE);
    mac_a_d     = mac_valid_d ? data_d[idx_d]  : '0;
    mac_b_d     = mac_valid_d ? multi_d[idx_d] : '0;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      data_q      <= '0;
      multi_q     <= '0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      mac_reset_q <= 1'b0;
      mac_valid_q <= 1'b0;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      multi_q     <= multi_d;
      result_q    <= result_d;
      overflow_q  <= overflow_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      mac_reset_q <= mac_reset_d;
      mac_valid_q <= mac_valid_d;
      mac_a_q     <= mac_a_d;
      mac_b_q     <= mac_b_d;
    end
  end

  assign busy      = busy_q;
  assign mac_reset = mac_reset_q;
  assign mac_valid = mac_valid_q;
  assign mac_a     = mac_a_q;
  assign mac_b     = mac_b_q;
  assign result    = result_q;
  assign overflow  = overflow_q;
  assign done      = done_q;

endmodule

// File: tb/tb_mac_feeder.sv
// Bench for mac_feeder: a default instance and a RESULT_W=8/LAT=3 instance share stimulus, each driving its own MAC model.
module tb_mac_feeder;
  localparam int DW = 4;
  localparam int N = 8;
  localparam int RWA = 16;
  localparam int RWB = 8;
  localparam int LATB = 3;
`ifdef MAC_FEEDER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  logic start = 1'b0;
  logic mac_ready = 1'b1;
  logic [N*DW-1:0] data_in = '0;
  logic [N*DW-1:0] multi_in = '0;

  logic busy_a, mrst_a, mval_a, movf_a, ovf_a, done_a;
  logic [DW-1:0] ma_a, mb_a;
  logic [RWA-1:0] mres_a, res_a;
  logic busy_b, mrst_b, mval_b, movf_b, ovf_b, done_b;
  logic [DW-1:0] ma_b, mb_b;
  logic [RWB-1:0] mres_b, res_b;

  always #5 clk = ~clk;

  mac_feeder u_dut_a (
    .clk(clk), .aresetn(aresetn), .start(start), .data_in(data_in), .multi_in(multi_in),
    .busy(busy_a), .mac_reset(mrst_a), .mac_valid(mval_a), .mac_ready(mac_ready),
    .mac_a(ma_a), .mac_b(mb_a), .mac_result(mres_a), .mac_overflow(movf_a),
    .result(res_a), .overflow(ovf_a), .done(done_a)
  );

  mac_feeder #(.RESULT_W(RWB), .LAT(LATB)) u_dut_b (
    .clk(clk), .aresetn(aresetn), .start(start), .data_in(data_in), .multi_in(multi_in),
    .busy(busy_b), .mac_reset(mrst_b), .mac_valid(mval_b), .mac_ready(mac_ready),
    .mac_a(ma_b), .mac_b(mb_b), .mac_result(mres_b), .mac_overflow(movf_b),
    .result(res_b), .overflow(ovf_b), .done(done_b)
  );

  // Behavioural MACs: wide accumulator, result LAT cycles after acceptance.
  int unsigned acc_a, acc_b, b_d1, b_d2;
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      acc_a <= 0; acc_b <= 0; b_d1 <= 0; b_d2 <= 0;
    end else begin
      if (mrst_a) acc_a <= 0;
      else if (mval_a && mac_ready) acc_a <= acc_a + 32'(ma_a) * 32'(mb_a);
      if (mrst_b) acc_b <= 0;
      else if (mval_b && mac_ready) acc_b <= acc_b + 32'(ma_b) * 32'(mb_b);
      b_d1 <= acc_b;
      b_d2 <= b_d1;
    end
  end
  assign mres_a = acc_a[RWA-1:0];
  assign movf_a = (acc_a > 32'd65535);
  assign mres_b = b_d2[RWB-1:0];
  assign movf_b = (b_d2 > 32'd255);

  typedef struct {
    logic [N*DW-1:0] d;
    logic [N*DW-1:0] m;
    logic [63:0]     stall;
    logic [63:0]     xstart;
    int              sum;
    int              done_cyc;
  } vec_t;

  vec_t tbl [4];
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_window(input vec_t v);
    int dcnt_a = 0, dcnt_b = 0, dcyc_a = -1, dcyc_b = -1, rst_cnt = 0, rst_cyc = -1;
    int npairs = 0, op_err = 0, hold_err = 0, zero_err = 0, busy_err_a = 0, busy_err_b = 0;
    longint ra = -1, oa = -1, rb = -1, ob = -1;
    logic [DW-1:0] pa = '0, pb = '0;
    logic pstall = 1'b0;
    bit exp_ob;
    longint exp_rb;
    for (int c = 0; c < v.done_cyc + 5; c++) begin
      @(negedge clk);
      if (done_a) begin dcnt_a++; dcyc_a = c; ra = res_a; oa = ovf_a; end
      if (done_b) begin dcnt_b++; dcyc_b = c; rb = res_b; ob = ovf_b; end
      if (mrst_a) begin rst_cnt++; rst_cyc = c; end
      if (busy_a != (c >= 1 && c <= v.done_cyc)) busy_err_a++;
      if (busy_b != (c >= 1 && c <= v.done_cyc + LATB - 1)) busy_err_b++;
      if (!mval_a && (ma_a != 0 || mb_a != 0)) zero_err++;
      if (pstall && (!mval_a || ma_a != pa || mb_a != pb)) hold_err++;
      start = (c == 0) || v.xstart[c];
      mac_ready = !v.stall[c];
      if (c == 0) begin
        data_in = v.d;
        multi_in = v.m;
      end else begin
        data_in = $urandom;
        multi_in = $urandom;
      end
      if (mval_a && mac_ready) begin
        if (npairs < N && (ma_a != v.d[npairs*DW +: DW] || mb_a != v.m[npairs*DW +: DW])) op_err++;
        npairs++;
      end
      pstall = mval_a && !mac_ready;
      pa = ma_a;
      pb = mb_a;
    end
    start = 1'b0;
    mac_ready = 1'b1;
    exp_ob = (v.sum > 255);
    exp_rb = (exp_ob && SAT) ? 255 : (v.sum % 256);
    check("done_count_a", dcnt_a, 1);
    check("done_cycle_a", dcyc_a, v.done_cyc);
    check("result_a", ra, v.sum % 65536);
    check("overflow_a", oa, longint'(v.sum > 65535));
    check("done_count_b", dcnt_b, 1);
    check("done_cycle_b", dcyc_b, v.done_cyc + LATB - 1);
    check("result_b", rb, exp_rb);
    check("overflow_b", ob, longint'(exp_ob));
    check("mac_reset_count", rst_cnt, 1);
    check("mac_reset_cycle", rst_cyc, 1);
    check("pairs_accepted", npairs, N);
    check("operand_errors", op_err, 0);
    check("stall_hold_errors", hold_err, 0);
    check("idle_operand_errors", zero_err, 0);
    check("busy_errors_a", busy_err_a, 0);
    check("busy_errors_b", busy_err_b, 0);
    check("result_held_a", res_a, v.sum % 65536);
  endtask

  task automatic reset_midwindow();
    int dn = 0;
    @(negedge clk);
    start = 1'b1;
    data_in = tbl[0].d;
    multi_in = tbl[0].m;
    for (int c = 1; c < 5; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    @(negedge clk);
    check("busy_before_abort", busy_a, 1);
    aresetn = 1'b0;
    #1;
    check("abort_outputs_a", {busy_a, mrst_a, mval_a, ma_a, mb_a, res_a, ovf_a, done_a}, 0);
    check("abort_outputs_b", {busy_b, mrst_b, mval_b, ma_b, mb_b, res_b, ovf_b, done_b}, 0);
    repeat (2) @(negedge clk);
    aresetn = 1'b1;
    repeat (15) begin
      @(negedge clk);
      dn += int'(done_a) + int'(done_b);
    end
    check("no_done_after_abort", dn, 0);
  endtask

  // Reference: sum of products and done cycle derived from when the 8th pair is accepted.
  function automatic vec_t random_vec();
    vec_t v;
    int acc = 0;
    int c = 2;
    v.d = $urandom;
    v.m = $urandom;
    v.stall = '0;
    v.xstart = '0;
    for (int i = 1; i <= 30; i++) v.stall[i] = ($urandom_range(0, 3) == 0);
    v.sum = 0;
    for (int i = 0; i < N; i++) v.sum += int'(v.d[i*DW +: DW]) * int'(v.m[i*DW +: DW]);
    forever begin
      if (!v.stall[c]) acc++;
      if (acc == N) break;
      c++;
    end
    v.done_cyc = c + 2;
    for (int i = 1; i <= v.done_cyc; i++) v.xstart[i] = ($urandom_range(0, 4) == 0);
    return v;
  endfunction

  initial begin
    tbl[0] = '{32'h11111111, 32'h22222222, 64'd0, 64'd0, 16, 11};
    tbl[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'd0, 64'd0, 1800, 11};
    tbl[2] = '{32'h76543210, 32'h11111111, 64'h48, 64'd0, 28, 13};
    tbl[3] = '{32'h11111111, 32'h22222222, 64'd0, 64'h810, 16, 11};

    repeat (2) @(negedge clk);
    check("reset_state_a", {busy_a, mrst_a, mval_a, ma_a, mb_a, res_a, ovf_a, done_a}, 0);
    check("reset_state_b", {busy_b, mrst_b, mval_b, ma_b, mb_b, res_b, ovf_b, done_b}, 0);
    aresetn = 1'b1;

    for (int i = 0; i < 4; i++) run_window(tbl[i]);
    for (int i = 0; i < 20; i++) run_window(random_vec());
    reset_midwindow();
    run_window(tbl[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
